// File: rtl/demux_1to9_capture_pkg.sv
// Shared definitions for the 1-to-9 serial capture block and its mux counterpart.
package demux_1to9_capture_pkg;

  localparam logic [3:0] SLOT_IDLE  = 4'd0;
  localparam logic [3:0] SLOT_FIRST = 4'd1;
  localparam logic [3:0] SLOT_LAST  = 4'd9;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  // Slot codes 1..9 address a bit; 0 is idle and 10..15 are invalid.
  function automatic logic slot_is_valid(input logic [3:0] s);
    return (s >= SLOT_FIRST) && (s <= SLOT_LAST);
  endfunction

endpackage

// File: rtl/slot_decoder_4to9.sv
// Combinational 4-bit slot code to 9-bit one-hot; all zeros for idle/invalid codes.
module slot_decoder_4to9
  import demux_1to9_capture_pkg::*;
(
  input  logic [3:0] sel,
  output logic [8:0] onehot
);

  // Decode the slot code into a single set bit at position (sel - 1).
  always_comb begin
    // NOTE: default assigned first so every path drives onehot and no latch is inferred.
    onehot = '0;
    if (slot_is_valid(sel)) begin
      onehot = 9'd1 << (sel - SLOT_FIRST);
    end
  end

endmodule

// File: rtl/demux_1to9_capture.sv
// Serial-to-parallel receiver: rebuilds a 9-bit word from bits steered into
// slots 1..9, plus addressed single-bit writes into the output word.
module demux_1to9_capture
  import demux_1to9_capture_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int          TO_W           = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       bit_in,
  input  logic       bit_valid,
  input  logic       wr_en,
  input  logic [3:0] wr_sel,
  input  logic       wr_bit,
  output logic [3:0] slot,
  output logic       busy,
  output logic [8:0] data_out,
  output logic       data_valid,
  output logic       timeout_err
);

  localparam bit            TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);

  state_t            state, state_nx;
  logic [3:0]        slot_nx;
  logic [8:0]        shadow, shadow_nx;
  logic [TO_W-1:0]   to_cnt, to_cnt_nx;
  logic [8:0]        data_nx;
  logic              data_valid_nx, timeout_err_nx;
  logic              frame_done;
  logic [8:0]        shadow_hot, wr_hot;

  slot_decoder_4to9 u_shadow_dec (
    .sel    (slot),
    .onehot (shadow_hot)
  );

  slot_decoder_4to9 u_wr_dec (
    .sel    (wr_sel),
    .onehot (wr_hot)
  );

  // State register; busy is registered alongside the state it mirrors.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state <= state_nx;
      busy  <= (state_nx == RECV);
    end
  end

  // Next-state and next-output logic: start beats bit_valid, completion beats wr_en.
  always_comb begin
    state_nx       = state;
    slot_nx        = slot;
    shadow_nx      = shadow;
    to_cnt_nx      = to_cnt;
    data_nx        = data_out;
    data_valid_nx  = 1'b0;
    timeout_err_nx = 1'b0;
    frame_done     = 1'b0;

    if (start) begin
      state_nx  = RECV;
      slot_nx   = SLOT_FIRST;
      shadow_nx = '0;
      to_cnt_nx = '0;
    end else if (state == RECV) begin
      if (bit_valid) begin
        shadow_nx = (shadow & ~shadow_hot) | (shadow_hot & {9{bit_in}});
        to_cnt_nx = '0;
        if (slot == SLOT_LAST) begin
          // Bit 8 lands via shadow_nx, so the completed word includes this cycle's bit.
          data_nx       = shadow_nx;
          data_valid_nx = 1'b1;
          state_nx      = IDLE;
          slot_nx       = SLOT_IDLE;
          frame_done    = 1'b1;
        end else begin
          slot_nx = slot + 4'd1;
        end
      end else if (TO_EN && (to_cnt == TO_LAST)) begin
        state_nx       = IDLE;
        slot_nx        = SLOT_IDLE;
        to_cnt_nx      = '0;
        timeout_err_nx = 1'b1;
      end else begin
        to_cnt_nx = to_cnt + TO_W'(1);
      end
    end

    if (wr_en && !frame_done) begin
      data_nx = (data_out & ~wr_hot) | (wr_hot & {9{wr_bit}});
    end
  end

  // Datapath registers: slot, shadow word, timeout counter and output word/pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot        <= SLOT_IDLE;
      shadow      <= '0;
      to_cnt      <= '0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      slot        <= slot_nx;
      shadow      <= shadow_nx;
      to_cnt      <= to_cnt_nx;
      data_out    <= data_nx;
      data_valid  <= data_valid_nx;
      timeout_err <= timeout_err_nx;
    end
  end

endmodule

// File: doc/demux_1to9_capture.md
Name: demux_1to9_capture

Overview:
- Serial-to-parallel receiver, the counterpart of the 9-input select mux; the mux serialises a 9-bit word by stepping select 1..9, and this block rebuilds that word.
- Accepts one data bit per valid strobe and steers it into slot 1..9 using the same 4-bit slot encoding: 0 = idle, 1..9 = bit index+1, 10..15 = invalid.
- Also accepts direct addressed single-bit writes.
- Presents the assembled 9-bit word with a one-cycle valid pulse. Sits in the project top between the input pins and the datapath.

Parameters:
- TIMEOUT_CYCLES, 16, max idle cycles between bit_valid strobes inside a frame before abort; 0 disables the timeout.
- TO_W, 5, width of the timeout counter; must satisfy 2**TO_W > TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  begin a serial frame (pulse)
- bit_in  input  1  serial data bit
- bit_valid  input  1  bit_in is valid this cycle
- wr_en  input  1  addressed write strobe
- wr_sel  input  4  addressed slot: 1..9 valid, others ignored
- wr_bit  input  1  addressed write data
- slot  output  4  slot the next serial bit lands in; 0 when idle
- busy  output  1  frame in progress
- data_out  output  9  last completed / current word
- data_valid  output  1  one-cycle pulse when a frame completes
- timeout_err  output  1  one-cycle pulse on a frame abort due to timeout

Behaviour:
- Reset (async, rst=1): state IDLE; slot=0, busy=0, data_out=0, data_valid=0, timeout_err=0; shadow word and timeout counter cleared.
- All outputs are registered.
- FSM states:
  - IDLE:
    - start=1 -> RECV; slot<=1, shadow<=0, timeout counter<=0.
    - bit_valid in IDLE is ignored.
  - RECV:
    - bit_valid=1 -> shadow[slot-1]<=bit_in; counter<=0.
    - If slot<9: slot<=slot+1.
    - If slot==9: data_out<={bit_in, shadow[7:0]} (bit 8 taken from bit_in the same cycle); data_valid<=1 for one cycle; -> IDLE; slot<=0.
    - bit_valid=0 -> counter increments.
    - If TIMEOUT_CYCLES!=0 and counter reaches TIMEOUT_CYCLES-1 -> IDLE, slot<=0, timeout_err pulse one cycle; data_out unchanged.
    - start=1 while in RECV restarts the frame: slot<=1, shadow<=0, counter<=0. The current bit_valid is dropped; start has priority over bit_valid.
- busy = (state==RECV), registered together with the state.
- Latency: data_valid asserts the cycle after the 9th bit_valid edge; 9 bits need a minimum of 10 cycles from start.
- Addressed write:
  - wr_en=1 with wr_sel in 1..9 -> data_out[wr_sel-1]<=wr_bit next cycle.
  - wr_sel 0 or 10..15 -> no effect, mirroring the mux default.
  - No data_valid pulse for addressed writes.
- Priority on the same cycle: frame completion overwrites all of data_out and wins over wr_en. Otherwise wr_en applies regardless of FSM state.
- Reset mid-frame discards the partial word and clears data_out.

Decomposition:
- Shared package holds:
  - SLOT_IDLE=4'd0, SLOT_FIRST=4'd1, SLOT_LAST=4'd9;
  - the FSM state typedef (IDLE, RECV);
  - a slot_is_valid function returning 1 for 1..9, also usable by the mux.
- One natural sub-module: slot_decoder_4to9, a combinational 4-bit slot to 9-bit one-hot decoder, zero for invalid codes. It is used for both shadow and addressed writes.

Test Plan:
- Reset, then start, then 9 consecutive bit_valid with bits 1,0,1,1,0,0,1,0,1 -> data_out=9'b101001101, data_valid high exactly one cycle, slot sequence 1..9 then 0.
- Start, 4 bits, then bit_valid low for 16 cycles -> timeout_err pulse, busy=0, slot=0, data_out unchanged.
- Start, 5 bits, start again, 9 bits of all ones -> data_out=9'h1FF; only one data_valid pulse.
- Idle; wr_en with wr_sel=4, wr_bit=1 -> data_out[3]=1; wr_sel=0 and wr_sel=12 -> data_out unchanged.
- wr_en (wr_sel=1, wr_bit=1) on the cycle of the 9th bit with all-zero frame -> data_out=0 (completion wins).
- Assert rst asynchronously mid-frame (slot=6) -> all outputs 0 immediately, without waiting for a clock edge; bit_valid afterwards is ignored until start.
